// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the byte-RAM access controller.
package ram_ctrl_pkg;

   localparam int NUM_WR = 2;
   localparam int RD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry byte FIFO catching RAM read data ahead of the output stream.
module ram_rd_skid (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic [1:0] count,
   output logic       full,
   output logic       empty
);

   logic [7:0] mem [2];
   logic       wr_ptr;
   logic       rd_ptr;

   // storage, no reset needed: entries are only read once counted valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Write-port arbiter and burst-read sequencer for the dual-port byte RAM.
//
// state | meaning
// IDLE  | no burst; waits for rd_start
// RUN   | issuing reads while credit allows
// DRAIN | all reads issued; waits for final byte to be accepted
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDRL = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_WR-1:0]       wr_valid,
   input  logic [NUM_WR*ADDRL-1:0] wr_addr,
   input  logic [NUM_WR*8-1:0]     wr_data,
   output logic [NUM_WR-1:0]       wr_ready,
   input  logic                    rd_start,
   input  logic [ADDRL-1:0]        rd_base,
   input  logic [ADDRL:0]          rd_len,
   output logic [7:0]              rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    rd_busy,
   output logic                    rd_done,
   output logic                    ram_ena,
   output logic                    ram_wea,
   output logic [ADDRL-1:0]        ram_addra,
   output logic [7:0]              ram_dia,
   output logic                    ram_enb,
   output logic [ADDRL-1:0]        ram_addrb,
   input  logic [7:0]              ram_dob
);

   // one read in flight plus one already buffered fills the 2-entry skid
   localparam int CREDITS = RD_LAT + 1;

   logic [NUM_WR-1:0] gnt;
   logic              rr_ptr;
   rd_state_t         state;
   logic [ADDRL:0]    rem;
   logic [ADDRL-1:0]  nxt_addr;
   logic              rd_pop;
   logic [1:0]        sk_count;
   logic              sk_full;
   logic              sk_empty;
   logic [2:0]        occ;
   logic              credit_ok;

   // grant: single requester wins outright, contention goes to the pointer
   always_comb begin
      gnt = wr_valid;
      if (wr_valid == 2'b11) gnt = rr_ptr ? 2'b10 : 2'b01;
   end

   assign wr_ready  = gnt;
   assign ram_ena   = |gnt;
   assign ram_wea   = |gnt;
   assign ram_addra = gnt[1] ? wr_addr[ADDRL +: ADDRL] : wr_addr[ADDRL-1:0];
   assign ram_dia   = gnt[1] ? wr_data[15:8] : wr_data[7:0];

   // pointer prefers the requester that was not served last
   always_ff @(posedge clk) begin
      if (reset)     rr_ptr <= 1'b0;
      else if (|gnt) rr_ptr <= gnt[0];
   end

   // ram_enb is the in-flight flag: its data lands in the skid at the next edge
   ram_rd_skid u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (ram_enb),
      .push_data (ram_dob),
      .pop       (rd_pop),
      .head      (rd_data),
      .count     (sk_count),
      .full      (sk_full),
      .empty     (sk_empty)
   );

   assign rd_valid = ~sk_empty;
   assign rd_pop   = rd_valid & rd_ready;
   assign rd_busy  = (state != IDLE);

   // occupancy after this edge; a pop this cycle frees a slot for a new issue
   assign occ       = {1'b0, sk_count} + {2'b00, ram_enb} - {2'b00, rd_pop};
   assign credit_ok = (occ < 3'(CREDITS));

   // read sequencer; the first read issues straight from IDLE to save a cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ram_enb   <= 1'b0;
         ram_addrb <= '0;
         nxt_addr  <= '0;
         rem       <= '0;
         rd_done   <= 1'b0;
      end else begin
         ram_enb <= 1'b0;
         rd_done <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_start) begin
                  if (rd_len == '0) begin
                     rd_done <= 1'b1;
                  end else begin
                     ram_enb   <= 1'b1;
                     ram_addrb <= rd_base;
                     nxt_addr  <= rd_base + ADDRL'(1);
                     rem       <= rd_len - (ADDRL+1)'(1);
                     state     <= (rd_len == (ADDRL+1)'(1)) ? DRAIN : RUN;
                  end
               end
            end
            RUN: begin
               if (credit_ok) begin
                  ram_enb   <= 1'b1;
                  ram_addrb <= nxt_addr;
                  nxt_addr  <= nxt_addr + ADDRL'(1);
                  rem       <= rem - (ADDRL+1)'(1);
                  if (rem == (ADDRL+1)'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               // nothing in flight and a single byte left being taken
               if (!ram_enb && !sk_full && rd_pop) begin
                  rd_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural negedge byte RAM.
module tb_ram_access_ctrl;

   localparam int ADDRL = 14;

   logic                 clk;
   logic                 reset;
   logic [1:0]           wr_valid;
   logic [2*ADDRL-1:0]   wr_addr;
   logic [15:0]          wr_data;
   logic [1:0]           wr_ready;
   logic                 rd_start;
   logic [ADDRL-1:0]     rd_base;
   logic [ADDRL:0]       rd_len;
   logic [7:0]           rd_data;
   logic                 rd_valid;
   logic                 rd_ready;
   logic                 rd_busy;
   logic                 rd_done;
   logic                 ram_ena;
   logic                 ram_wea;
   logic [ADDRL-1:0]     ram_addra;
   logic [7:0]           ram_dia;
   logic                 ram_enb;
   logic [ADDRL-1:0]     ram_addrb;
   logic [7:0]           ram_dob;

   logic [7:0] mem    [0:(1<<ADDRL)-1];
   logic [7:0] shadow [0:(1<<ADDRL)-1];

   int total;
   int bad;

   ram_access_ctrl #(.ADDRL(ADDRL)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_start  (rd_start),
      .rd_base   (rd_base),
      .rd_len    (rd_len),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_busy   (rd_busy),
      .rd_done   (rd_done),
      .ram_ena   (ram_ena),
      .ram_wea   (ram_wea),
      .ram_addra (ram_addra),
      .ram_dia   (ram_dia),
      .ram_enb   (ram_enb),
      .ram_addrb (ram_addrb),
      .ram_dob   (ram_dob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input logic [13:0] a);
      return a[7:0] ^ {2'b10, a[13:8]};
   endfunction

   // RAM model: read samples before the write so same-address reads see old data
   initial begin
      ram_dob = 8'h00;
      for (int a = 0; a < (1 << ADDRL); a++) mem[a] = init_val(14'(a));
      forever begin
         @(negedge clk);
         if (ram_enb) ram_dob <= mem[ram_addrb];
         if (ram_ena && ram_wea) mem[ram_addra] = ram_dia;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input logic [13:0] base, input logic [14:0] len, input int mode,
                            input logic wv, input logic [13:0] wa, input logic [7:0] wd,
                            input int junk_cyc, output int first_v, output int done_c);
      int c, issued, rcvd, cnt;
      logic prev_enb, prev_pop, prev_stall, done;
      logic [7:0] prev_data, exp_d;
      logic [13:0] a;
      c = 0; issued = 0; rcvd = 0; cnt = 0;
      prev_enb = 0; prev_pop = 0; prev_stall = 0; prev_data = 0; done = 0;
      first_v = -1; done_c = -1;
      while (!done && c < 300) begin
         tick();
         cnt = cnt + int'(prev_enb) - int'(prev_pop);
         rd_start = (c == 0) || (c == junk_cyc);
         if (c == junk_cyc) begin
            rd_base = 14'h0800; rd_len = 15'd9;
         end else if (c == 0) begin
            rd_base = base; rd_len = len;
         end
         wr_valid = (c == 0 && wv) ? 2'b10 : 2'b00;
         wr_addr  = {wa, 14'h0};
         wr_data  = {wd, 8'h0};
         rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
         #1;
         if (c == 0 && wv) begin
            total++;
            if ({wr_ready, ram_ena, ram_addra, ram_dia} !== {2'b10, 1'b1, wa, wd}) begin
               bad++;
               $display("FAIL burst_write_grant got=%b/%b/%h/%h want=10/1/%h/%h",
                        wr_ready, ram_ena, ram_addra, ram_dia, wa, wd);
            end
            shadow[wa] = wd;
         end
         if (ram_enb) begin
            a = base + 14'(issued);
            total++;
            if (ram_addrb !== a) begin
               bad++;
               $display("FAIL burst_addr idx=%0d got=%h want=%h", issued, ram_addrb, a);
            end
            total++;
            if (cnt >= 2) begin
               bad++;
               $display("FAIL issue_when_full held=%0d want<2", cnt);
            end
            issued++;
         end
         total++;
         if (rd_valid !== (cnt != 0)) begin
            bad++;
            $display("FAIL rd_valid_vs_held c=%0d got=%b held=%0d", c, rd_valid, cnt);
         end
         if (prev_stall) begin
            total++;
            if (!(rd_valid === 1'b1 && rd_data === prev_data)) begin
               bad++;
               $display("FAIL stall_stable got=%b/%h want=1/%h", rd_valid, rd_data, prev_data);
            end
         end
         if (rd_valid && first_v < 0) first_v = c;
         if (rd_valid && rd_ready) begin
            a = base + 14'(rcvd);
            exp_d = shadow[a];
            total++;
            if (rd_data !== exp_d) begin
               bad++;
               $display("FAIL stream_data idx=%0d got=%h want=%h", rcvd, rd_data, exp_d);
            end
            rcvd++;
         end
         if (rd_done) begin
            done = 1;
            done_c = c;
            total++;
            if (rd_busy !== 1'b0) begin
               bad++;
               $display("FAIL busy_at_done got=%b want=0", rd_busy);
            end
         end
         prev_enb   = ram_enb;
         prev_pop   = rd_valid && rd_ready;
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
         c++;
      end
      rd_start = 0;
      wr_valid = 2'b00;
      rd_ready = 1'b1;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL burst_timeout base=%h len=%0d got=no_done want=done", base, len);
      end
      total++;
      if (rcvd != int'(len) || issued != int'(len)) begin
         bad++;
         $display("FAIL burst_count got=%0d/%0d want=%0d", rcvd, issued, len);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({rd_valid, rd_busy, rd_done, ram_enb, ram_ena, wr_ready} !== 6'b0) begin
         bad++;
         $display("FAIL reset_state got=%b want=000000",
                  {rd_valid, rd_busy, rd_done, ram_enb, ram_ena, wr_ready});
      end
      reset = 1'b0;
   endtask

   task automatic test_write_read;
      int fv, dc;
      tick();
      wr_valid = 2'b01;
      wr_addr  = {14'h0, 14'h0010};
      wr_data  = {8'h00, 8'hA5};
      #1;
      total++;
      if ({wr_ready, ram_ena, ram_wea, ram_addra, ram_dia} !== {2'b01, 1'b1, 1'b1, 14'h0010, 8'hA5}) begin
         bad++;
         $display("FAIL wr0_grant got=%b/%b/%b/%h/%h want=01/1/1/0010/a5",
                  wr_ready, ram_ena, ram_wea, ram_addra, ram_dia);
      end
      shadow[14'h0010] = 8'hA5;
      run_burst(14'h0010, 15'd2, 0, 1'b1, 14'h0011, 8'h3C, -1, fv, dc);
      total++;
      if (fv != 2) begin
         bad++;
         $display("FAIL first_valid_cycle got=%0d want=2", fv);
      end
      total++;
      if (dc != 4) begin
         bad++;
         $display("FAIL done_cycle got=%0d want=4", dc);
      end
   endtask

   task automatic test_round_robin;
      logic [1:0] eg;
      for (int i = 0; i < 4; i++) begin
         tick();
         wr_valid = 2'b11;
         wr_addr  = {14'h0210 + 14'(i), 14'h0200 + 14'(i)};
         wr_data  = {8'hB0 + 8'(i), 8'hC0 + 8'(i)};
         #1;
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         total++;
         if (wr_ready !== eg ||
             ram_addra !== ((i % 2 == 0) ? 14'h0200 + 14'(i) : 14'h0210 + 14'(i)) ||
             ram_dia !== ((i % 2 == 0) ? 8'hC0 + 8'(i) : 8'hB0 + 8'(i))) begin
            bad++;
            $display("FAIL rr_grant i=%0d got=%b/%h/%h want=%b", i, wr_ready, ram_addra, ram_dia, eg);
         end
      end
      tick();
      wr_valid = 2'b01;
      #1;
      total++;
      if (wr_ready !== 2'b01) begin
         bad++;
         $display("FAIL single_req0 got=%b want=01", wr_ready);
      end
      tick();
      wr_valid = 2'b00;
      reset = 1'b1;
      #1;
      total++;
      if ({wr_ready, ram_ena, ram_wea} !== 4'b0000) begin
         bad++;
         $display("FAIL no_request got=%b want=0000", {wr_ready, ram_ena, ram_wea});
      end
      tick();
      reset = 1'b0;
      wr_valid = 2'b11;
      #1;
      total++;
      if (wr_ready !== 2'b01) begin
         bad++;
         $display("FAIL rr_after_reset got=%b want=01", wr_ready);
      end
      tick();
      #1;
      total++;
      if (wr_ready !== 2'b10) begin
         bad++;
         $display("FAIL rr_after_reset_2nd got=%b want=10", wr_ready);
      end
      tick();
      wr_valid = 2'b00;
   endtask

   task automatic test_wrap;
      int fv, dc;
      run_burst(14'h3FFE, 15'd4, 0, 1'b0, 14'h0, 8'h0, -1, fv, dc);
   endtask

   task automatic test_backpressure;
      int fv, dc;
      run_burst(14'h0100, 15'd8, 1, 1'b0, 14'h0, 8'h0, -1, fv, dc);
   endtask

   task automatic test_zero_len_and_ignore;
      int fv, dc;
      run_burst(14'h0000, 15'd0, 0, 1'b0, 14'h0, 8'h0, -1, fv, dc);
      total++;
      if (dc != 1 || fv != -1) begin
         bad++;
         $display("FAIL zero_len got=done@%0d valid@%0d want=done@1 valid@-1", dc, fv);
      end
      tick();
      total++;
      if ({rd_done, rd_valid, rd_busy} !== 3'b000) begin
         bad++;
         $display("FAIL zero_len_after got=%b want=000", {rd_done, rd_valid, rd_busy});
      end
      run_burst(14'h0040, 15'd3, 0, 1'b0, 14'h0, 8'h0, 1, fv, dc);
   endtask

   task automatic test_reset_mid_burst;
      int c, rcvd, fv, dc;
      logic [7:0] exp_d;
      c = 0; rcvd = 0;
      while (rcvd < 3 && c < 50) begin
         tick();
         rd_start = (c == 0);
         rd_base  = 14'h0050;
         rd_len   = 15'd6;
         rd_ready = 1'b1;
         #1;
         if (rd_valid && rd_ready) begin
            exp_d = shadow[14'h0050 + 14'(rcvd)];
            total++;
            if (rd_data !== exp_d) begin
               bad++;
               $display("FAIL pre_reset_data idx=%0d got=%h want=%h", rcvd, rd_data, exp_d);
            end
            rcvd++;
         end
         c++;
      end
      rd_start = 1'b0;
      total++;
      if (rcvd != 3) begin
         bad++;
         $display("FAIL pre_reset_timeout got=%0d want=3", rcvd);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      total++;
      if ({rd_valid, rd_busy} !== 2'b00) begin
         bad++;
         $display("FAIL reset_mid_drop got=%b want=00", {rd_valid, rd_busy});
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({rd_done, rd_valid, ram_enb} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_quiet i=%0d got=%b want=000", i, {rd_done, rd_valid, ram_enb});
         end
         tick();
      end
      run_burst(14'h0050, 15'd6, 0, 1'b0, 14'h0, 8'h0, -1, fv, dc);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      wr_valid = 2'b00;
      wr_addr  = '0;
      wr_data  = '0;
      rd_start = 1'b0;
      rd_base  = '0;
      rd_len   = '0;
      rd_ready = 1'b1;
      for (int a = 0; a < (1 << ADDRL); a++) shadow[a] = init_val(14'(a));
      test_reset();
      test_write_read();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_zero_len_and_ignore();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
